// File: rtl/store_rmw_unit_pkg.sv
// Shared store-path definitions: splice_store size codes and RMW sequencer states.
// Pure declarations; no latency, no flow control.
package store_rmw_unit_pkg;

  localparam logic [1:0] SPL_SD = 2'd0;
  localparam logic [1:0] SPL_SW = 2'd1;
  localparam logic [1:0] SPL_SH = 2'd2;
  localparam logic [1:0] SPL_SB = 2'd3;

  typedef enum logic [1:0] {
    RMW_IDLE  = 2'd0,
    RMW_READ  = 2'd1,
    RMW_WRITE = 2'd2,
    RMW_ERR   = 2'd3
  } rmw_state_t;

endpackage

// File: rtl/store_merger.sv
// Splices sub-word store data into an old doubleword (little-endian byte lanes).
// Combinational, zero latency; no flow control.
module store_merger
  import store_rmw_unit_pkg::*;
(
  input  logic [63:0] old_i,
  input  logic [63:0] new_i,
  input  logic [1:0]  spl_i,
  input  logic [2:0]  off_i,
  output logic [63:0] merged_o
);

  logic [7:0]  lane_base;
  logic [7:0]  lane_sel;
  logic [63:0] new_shifted;

  always_comb begin
    lane_base = 8'h01;
    case (spl_i)
      SPL_SD:  lane_base = 8'hFF;
      SPL_SW:  lane_base = 8'h0F;
      SPL_SH:  lane_base = 8'h03;
      default: lane_base = 8'h01;
    endcase
  end

  // Lanes past byte 7 fall off the top; callers only merge aligned stores.
  assign lane_sel    = lane_base << off_i;
  assign new_shifted = new_i << {off_i, 3'b000};

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < 8; i++) begin
      if (lane_sel[i]) merged_o[8*i +: 8] = new_shifted[8*i +: 8];
    end
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store sequencer: read-modify-write of the aligned doubleword for SB/SH/SW, direct write for SD.
// Latency MEM_LAT+1 (SD and misaligned: 1); no backpressure, start is ignored while busy.
module store_rmw_unit
  import store_rmw_unit_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  spl,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_addr,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err_misalign
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  rmw_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    spl_q;
  logic [63:0]   addr_q, wdata_q, old_q;
  logic          latch_req, capture_old;

  function automatic logic misaligned(input logic [1:0] s, input logic [2:0] a);
    case (s)
      SPL_SD:  return a != 3'd0;
      SPL_SW:  return a[1:0] != 2'd0;
      SPL_SH:  return a[0];
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    latch_req   = 1'b0;
    capture_old = 1'b0;
    case (state_q)
      RMW_IDLE: begin
        if (start) begin
          latch_req = 1'b1;
          cnt_d     = '0;
          if (misaligned(spl, addr[2:0])) state_d = RMW_ERR;
          else if (spl == SPL_SD)         state_d = RMW_WRITE;
          else                            state_d = RMW_READ;
        end
      end
      RMW_READ: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(MEM_LAT - 1)) begin
          capture_old = 1'b1;
          state_d     = RMW_WRITE;
        end
      end
      RMW_WRITE: state_d = RMW_IDLE;
      RMW_ERR:   state_d = RMW_IDLE;
      default:   state_d = RMW_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RMW_IDLE;
      cnt_q   <= '0;
      spl_q   <= SPL_SD;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_req) begin
        spl_q   <= spl;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (capture_old) old_q <= mem_rdata;
    end
  end

  store_merger u_merger (
    .old_i    (old_q),
    .new_i    (wdata_q),
    .spl_i    (spl_q),
    .off_i    (addr_q[2:0]),
    .merged_o (mem_wdata)
  );

  // All outputs come from registers, so reset drops mem_wr asynchronously.
  assign mem_addr     = {addr_q[63:3], 3'b000};
  assign mem_wr       = (state_q == RMW_WRITE);
  assign done         = (state_q == RMW_WRITE) || (state_q == RMW_ERR);
  assign err_misalign = (state_q == RMW_ERR);
  assign busy         = (state_q != RMW_IDLE);

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: directed table, reset/abort sequences, random stores vs. byte-lane memory model.
module tb_store_rmw_unit;
  import store_rmw_unit_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  spl;
  logic [63:0] addr, wdata, mem_rdata, mem_addr, mem_wdata;
  logic        mem_wr, busy, done, err_misalign;

  int vectors = 0;
  int miscompares = 0;

  store_rmw_unit #(.MEM_LAT(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .spl          (spl),
    .addr         (addr),
    .wdata        (wdata),
    .mem_rdata    (mem_rdata),
    .mem_addr     (mem_addr),
    .mem_wr       (mem_wr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .err_misalign (err_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  s;
    logic [63:0] a, wd, rd, exp;
    logic        err;
    bit          poke;
  } vec_t;

  vec_t tbl[10];
  logic [63:0] mem [logic [63:0]];

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      SPL_SD:  return 8;
      SPL_SW:  return 4;
      SPL_SH:  return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic ref_misalign(input logic [1:0] s, input logic [63:0] a);
    return (a % 64'(nbytes(s))) != 64'd0;
  endfunction

  function automatic logic [63:0] ref_merge(input logic [63:0] old, input logic [63:0] wd,
                                            input logic [1:0] s, input logic [63:0] a);
    logic [63:0] res;
    int off;
    res = old;
    off = int'(a[2:0]);
    for (int i = 0; i < nbytes(s); i++)
      if (off + i < 8) res[(off+i)*8 +: 8] = wd[i*8 +: 8];
    return res;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_store(input logic [1:0] s, input logic [63:0] a, input logic [63:0] wd,
                           input logic [63:0] rd, input logic [63:0] exp_wd, input logic exp_err,
                           input bit poke, input string tag);
    int lat, wr_n, done_n, err_n, done_cyc, wr_cyc, busy_bad, addr_bad, err_nodone;
    logic [63:0] wr_dat;
    lat = (exp_err || s == SPL_SD) ? 1 : LAT + 1;
    wr_n = 0; done_n = 0; err_n = 0; done_cyc = -1; wr_cyc = -1;
    busy_bad = 0; addr_bad = 0; err_nodone = 0; wr_dat = '0;
    @(negedge clk);
    start = 1'b1; spl = s; addr = a; wdata = wd; mem_rdata = rnd64();
    @(posedge clk); #1;
    start = 1'b0; spl = 2'($urandom); addr = rnd64(); wdata = rnd64();
    for (int c = 1; c <= lat + 3; c++) begin
      mem_rdata = (c == LAT && lat == LAT + 1) ? rd : rnd64();
      if (poke && c == 1) begin
        start = 1'b1; spl = SPL_SD; addr = 64'h0;
      end
      @(negedge clk);
      if (busy !== (c <= lat)) busy_bad++;
      if (c <= lat && mem_addr !== {a[63:3], 3'b000}) addr_bad++;
      if (mem_wr === 1'b1) begin wr_n++; wr_dat = mem_wdata; wr_cyc = c; end
      if (done === 1'b1) begin done_n++; done_cyc = c; end
      if (err_misalign === 1'b1) begin err_n++; if (done !== 1'b1) err_nodone++; end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk({tag, ".done_count"}, 64'(done_n), 64'd1);
    chk({tag, ".done_cycle"}, 64'(done_cyc), 64'(lat));
    chk({tag, ".wr_count"}, 64'(wr_n), exp_err ? 64'd0 : 64'd1);
    chk({tag, ".err_count"}, 64'(err_n), exp_err ? 64'd1 : 64'd0);
    chk({tag, ".err_without_done"}, 64'(err_nodone), 64'd0);
    chk({tag, ".busy_bad_cycles"}, 64'(busy_bad), 64'd0);
    chk({tag, ".addr_bad_cycles"}, 64'(addr_bad), 64'd0);
    if (!exp_err) begin
      chk({tag, ".wdata"}, wr_dat, exp_wd);
      chk({tag, ".wr_cycle"}, 64'(wr_cyc), 64'(lat));
    end
  endtask

  initial begin
    int wr_seen;
    tbl[0] = '{SPL_SD, 64'h100, 64'h1122334455667788, 64'hDEADDEADDEADDEAD, 64'h1122334455667788, 1'b0, 1'b0};
    tbl[1] = '{SPL_SB, 64'h103, 64'h00000000000000AB, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFABFFFFFF, 1'b0, 1'b0};
    tbl[2] = '{SPL_SH, 64'h106, 64'h000000000000BEEF, 64'h0000000000000000, 64'hBEEF000000000000, 1'b0, 1'b1};
    tbl[3] = '{SPL_SW, 64'h104, 64'h00000000DEADBEEF, 64'h0123456789ABCDEF, 64'hDEADBEEF89ABCDEF, 1'b0, 1'b0};
    tbl[4] = '{SPL_SW, 64'h102, 64'h00000000CAFEF00D, 64'h0, 64'h0, 1'b1, 1'b0};
    tbl[5] = '{SPL_SH, 64'h101, 64'h0000000000001234, 64'h0, 64'h0, 1'b1, 1'b1};
    tbl[6] = '{SPL_SD, 64'h104, 64'h0102030405060708, 64'h0, 64'h0, 1'b1, 1'b0};
    tbl[7] = '{SPL_SB, 64'h107, 64'hFFFFFFFFFFFFFF5A, 64'h0000000000000000, 64'h5A00000000000000, 1'b0, 1'b1};
    tbl[8] = '{SPL_SH, 64'h100, 64'h0000000000001234, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAA1234, 1'b0, 1'b0};
    tbl[9] = '{SPL_SD, 64'h2F8, 64'hFEDCBA9876543210, 64'h5555555555555555, 64'hFEDCBA9876543210, 1'b0, 1'b1};

    reset = 1'b1; start = 1'b0; spl = SPL_SD; addr = '0; wdata = '0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.mem_wr", 64'(mem_wr), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.err_misalign", 64'(err_misalign), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.mem_addr", mem_addr, 64'd0);
    chk("reset.mem_wdata", mem_wdata, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      run_store(tbl[i].s, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].exp, tbl[i].err, tbl[i].poke,
                $sformatf("tbl%0d", i));

    // Abort an SB while it is still reading.
    @(negedge clk);
    start = 1'b1; spl = SPL_SB; addr = 64'h201; wdata = 64'h66;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("abort.busy_before", 64'(busy), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort.busy_now", 64'(busy), 64'd0);
    chk("abort.mem_wr_now", 64'(mem_wr), 64'd0);
    chk("abort.done_now", 64'(done), 64'd0);
    wr_seen = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_wr === 1'b1 || done === 1'b1 || busy === 1'b1) wr_seen++;
    end
    chk("abort.activity_after", 64'(wr_seen), 64'd0);
    run_store(SPL_SB, 64'h201, 64'h66, 64'h0123456789ABCDEF, 64'h0123456789AB66EF, 1'b0, 1'b0, "after_abort");

    for (int k = 0; k < 60; k++) begin
      logic [1:0]  s;
      logic [63:0] a, wd, dw, expv;
      logic        e;
      s  = 2'($urandom_range(0, 3));
      a  = rnd64();
      if ($urandom_range(0, 3) != 0) a = a & ~64'(nbytes(s) - 1);
      a  = 64'h1000 + (a & 64'h3F);
      wd = rnd64();
      dw = a >> 3;
      if (!mem.exists(dw)) mem[dw] = rnd64();
      e    = ref_misalign(s, a);
      expv = ref_merge(mem[dw], wd, s, a);
      run_store(s, a, wd, mem[dw], expv, e, $urandom_range(0, 4) == 0, $sformatf("rnd%0d", k));
      if (!e) mem[dw] = expv;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
